// File: rtl/tl_pkg.sv
// Shared types and light encodings for the traffic light controller.
package tl_pkg;

  // Controller states; codes 6 and 7 are unused and recover to CAR_GREEN.
  typedef enum logic [2:0] {
    CAR_GREEN  = 3'd0,
    CAR_YELLOW = 3'd1,
    ALL_RED_A  = 3'd2,
    PED_WALK   = 3'd3,
    PED_FLASH  = 3'd4,
    ALL_RED_B  = 3'd5
  } tlState_e;

  // Car light encoding {red, yellow, green}.
  localparam logic [2:0] CAR_LIGHT_RED    = 3'b100;
  localparam logic [2:0] CAR_LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] CAR_LIGHT_GREEN  = 3'b001;

  // Pedestrian light encoding {walk, dont_walk}.
  localparam logic [1:0] PED_LIGHT_WALK      = 2'b10;
  localparam logic [1:0] PED_LIGHT_DONT_WALK = 2'b01;
  localparam logic [1:0] PED_LIGHT_OFF       = 2'b00;

  // True when the dwell counter has reached the last tick of a state lasting 'ticks'.
  function automatic logic dwellDone(input logic [3:0] dwell, input int unsigned ticks);
    return dwell == 4'(ticks - 1);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with a history flop and rising-edge detect.
// The detector only arms after it has seen the input low following reset,
// so an input already high when reset releases does not look like an edge.
module sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;
  logic seen_q;
  logic armed_q;

  // Synchronizer chain plus arming: seen_q marks that s1_q holds a real sample.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      seen_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= async_i;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      seen_q  <= 1'b1;
      armed_q <= armed_q | (seen_q & ~s1_q);
    end
  end

  assign rise_o = s2_q & ~s3_q & armed_q;

endmodule

// File: rtl/traffic_light_fsm.sv
// Pedestrian-crossing traffic light controller driven by a prescaled tick.
module traffic_light_fsm
  import tl_pkg::*;
#(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 2,
  parameter int WALK_TICKS   = 5,
  parameter int FLASH_TICKS  = 3
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       slow_clk,
  input  logic       enable,
  input  logic       ped_req,
  output logic [2:0] car_light,
  output logic [1:0] ped_light,
  output logic       ped_pending,
  output logic [2:0] state_dbg
);

  tlState_e   state_q, state_d;
  logic [3:0] dwell_q, dwell_d;
  logic       pedPending_q, pedPending_d;
  logic       flashPhase_q, flashPhase_d;
  logic       tick;
  logic       pedRise;
  logic       qualTick;

  sync_edge uTickSync (
    .clk_i   (clk_in),
    .rst_ni  (reset_n),
    .async_i (slow_clk),
    .rise_o  (tick)
  );

  sync_edge uPedSync (
    .clk_i   (clk_in),
    .rst_ni  (reset_n),
    .async_i (ped_req),
    .rise_o  (pedRise)
  );

  assign qualTick = tick & enable;

  // State, dwell counter, pending request and flash phase registers.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= CAR_GREEN;
      dwell_q      <= 4'd0;
      pedPending_q <= 1'b0;
      flashPhase_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dwell_q      <= dwell_d;
      pedPending_q <= pedPending_d;
      flashPhase_q <= flashPhase_d;
    end
  end

  // Next-state logic: each state advances on a qualified tick at the end of its dwell.
  always_comb begin
    state_d      = state_q;
    dwell_d      = dwell_q;
    pedPending_d = pedPending_q;
    flashPhase_d = flashPhase_q;

    case (state_q)
      CAR_GREEN: begin
        if (qualTick) begin
          if (!dwellDone(dwell_q, GREEN_TICKS)) begin
            dwell_d = dwell_q + 4'd1;
          end else if (pedPending_q) begin
            state_d = CAR_YELLOW;
          end
        end
      end
      CAR_YELLOW: begin
        if (qualTick) begin
          if (dwellDone(dwell_q, YELLOW_TICKS)) state_d = ALL_RED_A;
          else                                  dwell_d = dwell_q + 4'd1;
        end
      end
      ALL_RED_A: begin
        if (qualTick) begin
          if (dwellDone(dwell_q, 1)) state_d = PED_WALK;
          else                       dwell_d = dwell_q + 4'd1;
        end
      end
      PED_WALK: begin
        if (qualTick) begin
          if (dwellDone(dwell_q, WALK_TICKS)) state_d = PED_FLASH;
          else                                dwell_d = dwell_q + 4'd1;
        end
      end
      PED_FLASH: begin
        if (qualTick) begin
          if (dwellDone(dwell_q, FLASH_TICKS)) begin
            state_d = ALL_RED_B;
          end else begin
            dwell_d      = dwell_q + 4'd1;
            flashPhase_d = ~flashPhase_q;
          end
        end
      end
      ALL_RED_B: begin
        if (qualTick) begin
          if (dwellDone(dwell_q, 1)) state_d = CAR_GREEN;
          else                       dwell_d = dwell_q + 4'd1;
        end
      end
      default: begin
        state_d = CAR_GREEN;
      end
    endcase

    // Every state change starts the new state with a fresh dwell and flash phase.
    if (state_d != state_q) begin
      dwell_d      = 4'd0;
      flashPhase_d = 1'b0;
    end

    // Serving the walk consumes the request, but a simultaneous new press wins.
    if (state_d == PED_WALK && state_q != PED_WALK) pedPending_d = 1'b0;
    if (pedRise) pedPending_d = 1'b1;
  end

  // Light decode straight from the state register so outputs carry no extra latency.
  always_comb begin
    car_light = CAR_LIGHT_GREEN;
    ped_light = PED_LIGHT_DONT_WALK;
    case (state_q)
      CAR_GREEN: begin
        car_light = CAR_LIGHT_GREEN;
        ped_light = PED_LIGHT_DONT_WALK;
      end
      CAR_YELLOW: begin
        car_light = CAR_LIGHT_YELLOW;
        ped_light = PED_LIGHT_DONT_WALK;
      end
      ALL_RED_A, ALL_RED_B: begin
        car_light = CAR_LIGHT_RED;
        ped_light = PED_LIGHT_DONT_WALK;
      end
      PED_WALK: begin
        car_light = CAR_LIGHT_RED;
        ped_light = PED_LIGHT_WALK;
      end
      PED_FLASH: begin
        car_light = CAR_LIGHT_RED;
        ped_light = flashPhase_q ? PED_LIGHT_OFF : PED_LIGHT_WALK;
      end
      default: begin
        car_light = CAR_LIGHT_GREEN;
        ped_light = PED_LIGHT_DONT_WALK;
      end
    endcase
  end

  assign ped_pending = pedPending_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Scenario bench for the traffic light controller with a tick-level reference model.
module tb_traffic_light_fsm;

  localparam int G = 4;
  localparam int Y = 2;
  localparam int W = 3;
  localparam int F = 2;

  logic       clk_in   = 1'b0;
  logic       reset_n  = 1'b0;
  logic       slow_clk = 1'b0;
  logic       enable   = 1'b1;
  logic       ped_req  = 1'b0;
  logic [2:0] car_light;
  logic [1:0] ped_light;
  logic       ped_pending;
  logic [2:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  // Reference model state, advanced once per slow_clk rising edge.
  int   mState = 0;
  int   mDwell = 0;
  bit   mPhase = 1'b0;
  logic mPend  = 1'b0;

  // Expected {state, car_light, ped_light, ped_pending} per tick.
  logic [8:0] expQ[$];

  traffic_light_fsm #(
    .GREEN_TICKS  (G),
    .YELLOW_TICKS (Y),
    .WALK_TICKS   (W),
    .FLASH_TICKS  (F)
  ) dut (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .slow_clk    (slow_clk),
    .enable      (enable),
    .ped_req     (ped_req),
    .car_light   (car_light),
    .ped_light   (ped_light),
    .ped_pending (ped_pending),
    .state_dbg   (state_dbg)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [8:0] modelVec();
    logic [2:0] car;
    logic [1:0] ped;
    logic [2:0] st;
    st  = mState[2:0];
    car = (mState == 0) ? 3'b001 : (mState == 1) ? 3'b010 : 3'b100;
    if (mState == 3)      ped = 2'b10;
    else if (mState == 4) ped = mPhase ? 2'b00 : 2'b10;
    else                  ped = 2'b01;
    return {st, car, ped, mPend};
  endfunction

  task automatic modelReset();
    mState = 0;
    mDwell = 0;
    mPhase = 1'b0;
    mPend  = 1'b0;
  endtask

  task automatic modelStep();
    int lim;
    if (mState == 0) begin
      if (mDwell < G - 1) mDwell++;
      else if (mPend == 1'b1) begin
        mState = 1;
        mDwell = 0;
        mPhase = 1'b0;
      end
    end else begin
      lim = (mState == 1) ? Y : (mState == 3) ? W : (mState == 4) ? F : 1;
      if (mDwell < lim - 1) begin
        mDwell++;
        if (mState == 4) mPhase = ~mPhase;
      end else begin
        mState = (mState == 5) ? 0 : mState + 1;
        mDwell = 0;
        mPhase = 1'b0;
        if (mState == 3) mPend = 1'b0;
      end
    end
  endtask

  task automatic applyReset();
    @(negedge clk_in);
    reset_n  = 1'b0;
    slow_clk = 1'b0;
    ped_req  = 1'b0;
    enable   = 1'b1;
    repeat (2) @(negedge clk_in);
    reset_n = 1'b1;
    modelReset();
    expQ.delete();
    repeat (3) @(negedge clk_in);
  endtask

  // One slow_clk period (10 high, 10 low); optional ped pulse and late enable rise.
  task automatic applyStimulus(input bit withPed, input bit enableLate, output logic pendSample);
    pendSample = 1'b0;
    @(negedge clk_in);
    slow_clk = 1'b1;
    if (withPed) ped_req = 1'b1;
    if (enable || enableLate) modelStep();
    if (withPed) mPend = 1'b1;
    expQ.push_back(modelVec());
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_in);
      if (enableLate && c == 2) enable = 1'b1;
      if (c == 3) pendSample = ped_pending;
      if (c == 5) ped_req = 1'b0;
    end
    slow_clk = 1'b0;
    repeat (10) @(negedge clk_in);
  endtask

  task automatic test_reset();
    logic [8:0] got;
    reset_n = 1'b0;
    repeat (3) @(negedge clk_in);
    got = {state_dbg, car_light, ped_light, ped_pending};
    checks++;
    if (got !== 9'b000_001_01_0) begin
      failures++;
      $display("[TB] FAIL reset_state got=%b expected=%b", got, 9'b000_001_01_0);
    end
  endtask

  task automatic test_idle_green();
    logic [8:0] got, exp;
    logic p3;
    applyReset();
    for (int t = 1; t <= 20; t++) begin
      applyStimulus(1'b0, 1'b0, p3);
      got = {state_dbg, car_light, ped_light, ped_pending};
      exp = (expQ.size() > 0) ? expQ.pop_front() : 9'h1ff;
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL idle_green tick%0d got=%b expected=%b", t, got, exp);
      end
    end
  endtask

  task automatic test_ped_cycle();
    logic [8:0] got, exp;
    logic p3;
    bit   sawFlashOn, sawFlashOff;
    sawFlashOn  = 1'b0;
    sawFlashOff = 1'b0;
    applyReset();
    for (int t = 1; t <= 13; t++) begin
      applyStimulus(t == 1, 1'b0, p3);
      if (t == 1) begin
        checks++;
        if (p3 !== 1'b1) begin
          failures++;
          $display("[TB] FAIL ped_pending_latency got=%b expected=1", p3);
        end
      end
      got = {state_dbg, car_light, ped_light, ped_pending};
      exp = (expQ.size() > 0) ? expQ.pop_front() : 9'h1ff;
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL ped_cycle tick%0d got=%b expected=%b", t, got, exp);
      end
      if (state_dbg == 3'd4 && ped_light == 2'b10) sawFlashOn = 1'b1;
      if (state_dbg == 3'd4 && ped_light == 2'b00 && sawFlashOn) sawFlashOff = 1'b1;
    end
    checks++;
    if (sawFlashOff !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flash_sequence got=%b expected=1", sawFlashOff);
    end
  endtask

  task automatic test_enable_freeze();
    logic [8:0] got, exp;
    logic p3;
    applyReset();
    for (int t = 1; t <= 17; t++) begin
      if (t == 6) enable = 1'b0;
      applyStimulus(t == 1, t == 16, p3);
      got = {state_dbg, car_light, ped_light, ped_pending};
      exp = (expQ.size() > 0) ? expQ.pop_front() : 9'h1ff;
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL enable_freeze tick%0d got=%b expected=%b", t, got, exp);
      end
    end
  endtask

  task automatic test_set_wins();
    logic [8:0] got, exp;
    logic p3;
    applyReset();
    for (int t = 1; t <= 21; t++) begin
      applyStimulus(t == 1 || t == 7, 1'b0, p3);
      if (t == 7) begin
        checks++;
        if (p3 !== 1'b1) begin
          failures++;
          $display("[TB] FAIL set_wins_pending got=%b expected=1", p3);
        end
      end
      got = {state_dbg, car_light, ped_light, ped_pending};
      exp = (expQ.size() > 0) ? expQ.pop_front() : 9'h1ff;
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL set_wins tick%0d got=%b expected=%b", t, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_walk();
    logic [8:0] got, exp;
    logic p3;
    applyReset();
    for (int t = 1; t <= 7; t++) begin
      applyStimulus(t == 1, 1'b0, p3);
      got = {state_dbg, car_light, ped_light, ped_pending};
      exp = (expQ.size() > 0) ? expQ.pop_front() : 9'h1ff;
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL reach_walk tick%0d got=%b expected=%b", t, got, exp);
      end
    end
    @(negedge clk_in);
    slow_clk = 1'b1;
    reset_n  = 1'b0;
    #1;
    got = {state_dbg, car_light, ped_light, ped_pending};
    checks++;
    if (got !== 9'b000_001_01_0) begin
      failures++;
      $display("[TB] FAIL async_reset got=%b expected=%b", got, 9'b000_001_01_0);
    end
    modelReset();
    @(negedge clk_in);
    reset_n = 1'b1;
    repeat (15) @(negedge clk_in);
    got = {state_dbg, car_light, ped_light, ped_pending};
    checks++;
    if (got !== 9'b000_001_01_0) begin
      failures++;
      $display("[TB] FAIL after_release got=%b expected=%b", got, 9'b000_001_01_0);
    end
    slow_clk = 1'b0;
    repeat (10) @(negedge clk_in);
    for (int t = 1; t <= 5; t++) begin
      applyStimulus(t == 1, 1'b0, p3);
      got = {state_dbg, car_light, ped_light, ped_pending};
      exp = (expQ.size() > 0) ? expQ.pop_front() : 9'h1ff;
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL post_reset tick%0d got=%b expected=%b", t, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_green();
    test_ped_cycle();
    test_enable_freeze();
    test_set_wins();
    test_reset_mid_walk();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
